// File: rtl/savestate_sequencer_if.sv
// rtl/savestate_sequencer_if.sv - DDR channel and local state RAM bus bundle for the savestate sequencer
interface savestate_sequencer_if #(
  parameter int BRAM_AW = 10
);
  logic [27:1]        ch_addr;
  logic [63:0]        ch_din;
  logic [63:0]        ch_dout;
  logic               ch_req;
  logic               ch_rnw;
  logic [7:0]         ch_be;
  logic               ch_ready;
  logic [BRAM_AW-1:0] mem_addr;
  logic [63:0]        mem_wdata;
  logic               mem_we;
  logic [63:0]        mem_rdata;

  modport master (
    output ch_addr, ch_din, ch_req, ch_rnw, ch_be, mem_addr, mem_wdata, mem_we,
    input  ch_dout, ch_ready, mem_rdata
  );

  modport slave (
    input  ch_addr, ch_din, ch_req, ch_rnw, ch_be, mem_addr, mem_wdata, mem_we,
    output ch_dout, ch_ready, mem_rdata
  );
endinterface

// File: rtl/savestate_sequencer.sv
// rtl/savestate_sequencer.sv - moves a savestate image between local RAM and DDR behind a magic/count header
module savestate_sequencer #(
  parameter int          BRAM_AW = 10,
  parameter logic [31:0] MAGIC   = 32'h5353_0001
) (
  input  logic                 DDRAM_CLK,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 dir,
  input  logic [27:1]          base_addr,
  input  logic [BRAM_AW:0]     word_cnt,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  savestate_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, HDR, HWAIT, CHK, MRD, DREQ, DWAIT, MWR, FIN
  } state_t;

  // Largest legal word count, in the save-count width and in the header-count width.
  localparam logic [BRAM_AW:0] DEPTH_W = {1'b1, {BRAM_AW{1'b0}}};
  localparam logic [31:0]      DEPTH32 = 32'd1 << BRAM_AW;

  state_t             state, state_nx;
  logic               dir_q;       // 1 = save, 0 = load
  logic [27:1]        ch_addr_q;
  logic [63:0]        ch_din_q;
  logic [63:0]        data_q;      // header on load, then each fetched data word
  logic [BRAM_AW:0]   cnt_q;
  logic [BRAM_AW-1:0] idx;
  logic               error_q;

  logic               save_bad;
  logic               hdr_bad;
  logic [BRAM_AW:0]   idx_p1;
  logic               last;

  assign save_bad = (word_cnt == '0) || (word_cnt > DEPTH_W);
  assign hdr_bad  = (data_q[63:32] != MAGIC) || (data_q[31:0] == 32'd0) || (data_q[31:0] > DEPTH32);
  assign idx_p1   = {1'b0, idx} + {{BRAM_AW{1'b0}}, 1'b1};
  assign last     = (idx_p1 == cnt_q);

  assign bus.ch_addr   = ch_addr_q;
  assign bus.ch_rnw    = ~dir_q;
  assign bus.ch_be     = 8'hFF;
  assign bus.mem_addr  = idx;
  assign bus.mem_wdata = data_q;
  assign error         = error_q;

  // State register.
  always_ff @(posedge DDRAM_CLK or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state: one request in flight at a time, ready only honoured while waiting.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (dir && save_bad) ? FIN : HDR;
      HDR:     state_nx = HWAIT;
      HWAIT:   if (bus.ch_ready) state_nx = dir_q ? MRD : CHK;
      CHK:     state_nx = hdr_bad ? FIN : DREQ;
      MRD:     state_nx = DREQ;
      DREQ:    state_nx = DWAIT;
      DWAIT:   if (bus.ch_ready) state_nx = dir_q ? (last ? FIN : MRD) : MWR;
      MWR:     state_nx = last ? FIN : DREQ;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decoded from state; on a save the RAM word goes straight out during DREQ, then is held.
  always_comb begin
    busy        = (state != IDLE) && (state != FIN);
    done        = (state == FIN);
    bus.ch_req  = (state == HDR) || (state == DREQ);
    bus.mem_we  = (state == MWR);
    bus.ch_din  = (state == DREQ && dir_q) ? bus.mem_rdata : ch_din_q;
  end

  // Datapath: command latch, address walk, word counter, captured data and sticky error.
  always_ff @(posedge DDRAM_CLK or negedge reset_n) begin
    if (!reset_n) begin
      dir_q     <= 1'b0;
      ch_addr_q <= '0;
      ch_din_q  <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      idx       <= '0;
      error_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          dir_q     <= dir;
          ch_addr_q <= base_addr & ~27'h3;
          ch_din_q  <= {MAGIC, {(31-BRAM_AW){1'b0}}, word_cnt};
          cnt_q     <= word_cnt;
          idx       <= '0;
          error_q   <= dir && save_bad;
        end
        HWAIT: if (bus.ch_ready) begin
          if (dir_q) ch_addr_q <= ch_addr_q + 27'd4;
          else       data_q    <= bus.ch_dout;
        end
        CHK: begin
          if (hdr_bad) begin
            error_q <= 1'b1;
          end else begin
            cnt_q     <= data_q[BRAM_AW:0];
            ch_addr_q <= ch_addr_q + 27'd4;
          end
        end
        DREQ: if (dir_q) ch_din_q <= bus.mem_rdata;
        DWAIT: if (bus.ch_ready) begin
          if (!dir_q) begin
            data_q <= bus.ch_dout;
          end else if (!last) begin
            idx       <= idx_p1[BRAM_AW-1:0];
            ch_addr_q <= ch_addr_q + 27'd4;
          end
        end
        MWR: if (!last) begin
          idx       <= idx_p1[BRAM_AW-1:0];
          ch_addr_q <= ch_addr_q + 27'd4;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_savestate_sequencer.sv
// tb/tb_savestate_sequencer.sv - randomized self-checking bench for savestate_sequencer with DDR/RAM models
module tb_savestate_sequencer;
  localparam int          AW    = 10;
  localparam int          DEPTH = 1 << AW;
  localparam logic [31:0] MAGIC = 32'h5353_0001;

  logic          DDRAM_CLK;
  logic          reset_n, start, dir, busy, done, error;
  logic [26:0]   base_addr;
  logic [AW:0]   word_cnt;

  savestate_sequencer_if #(.BRAM_AW(AW)) bus ();

  savestate_sequencer #(.BRAM_AW(AW), .MAGIC(MAGIC)) dut (
    .DDRAM_CLK (DDRAM_CLK),
    .reset_n   (reset_n),
    .start     (start),
    .dir       (dir),
    .base_addr (base_addr),
    .word_cnt  (word_cnt),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .bus       (bus)
  );

  initial begin
    DDRAM_CLK = 0;
    forever #5 DDRAM_CLK = ~DDRAM_CLK;
  end

  typedef struct packed { logic [26:0] addr; logic rnw; logic [63:0] din; } req_t;
  typedef struct packed { logic [AW-1:0] addr; logic [63:0] data; } wr_t;

  int          checks = 0, errors = 0;
  logic [63:0] ddr [logic [26:0]];
  logic [63:0] ram [DEPTH];
  req_t        exp_req[$];
  wr_t         exp_wr[$];
  logic        exp_err = 0;
  int          req_count = 0, we_count = 0, ready_pulses = 0;
  int          lat_fix = 0;
  bit          stray_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event, expected none", name);
  endtask

  function automatic logic [63:0] ddr_rd(input logic [26:0] a);
    return ddr.exists(a) ? ddr[a] : 64'h0;
  endfunction

  // Synchronous-read local RAM: address seen in one cycle, data out the next.
  initial begin
    logic [AW-1:0] a;
    logic          we;
    logic [63:0]   wd;
    bus.mem_rdata = '0; a = '0; we = 0; wd = '0;
    forever begin
      @(negedge DDRAM_CLK);
      a = bus.mem_addr; we = bus.mem_we; wd = bus.mem_wdata;
      @(posedge DDRAM_CLK); #1;
      bus.mem_rdata = ram[a];
      if (we) ram[a] = wd;
    end
  end

  // DDR channel responder with random or fixed latency and optional stray ready pulses.
  initial begin
    int          cd;
    logic [26:0] a;
    logic        rd;
    cd = 0; a = '0; rd = 0;
    bus.ch_ready = 0; bus.ch_dout = '0;
    forever begin
      @(negedge DDRAM_CLK);
      bus.ch_ready = 0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          bus.ch_ready = 1;
          ready_pulses++;
          bus.ch_dout = rd ? ddr_rd(a) : {$urandom, $urandom};
        end
      end else if (bus.ch_req) begin
        a  = bus.ch_addr;
        rd = bus.ch_rnw;
        if (!rd) ddr[a] = bus.ch_din;
        cd = (lat_fix > 0) ? lat_fix : $urandom_range(1, 6);
      end else if (stray_en && $urandom_range(0, 15) == 0) begin
        bus.ch_ready = 1;
        bus.ch_dout  = {$urandom, $urandom};
      end
    end
  end

  // Compare process: every cycle, DUT traffic against the expected transaction lists.
  initial begin
    logic outst;
    req_t held, e;
    wr_t  w;
    outst = 0; held = '0;
    forever begin
      @(negedge DDRAM_CLK); #2;
      if (!reset_n) begin
        outst = 0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_req", bus.ch_req, 0);
        chk("rst_we", bus.mem_we, 0);
      end else begin
        chk("ch_be", bus.ch_be, 8'hFF);
        if (bus.ch_req) begin
          req_count++;
          if (outst) fail_now("second_req_outstanding");
          if (exp_req.size() == 0) begin
            fail_now("unexpected_ch_req");
          end else begin
            e = exp_req.pop_front();
            chk("req_addr", bus.ch_addr, e.addr);
            chk("req_rnw", bus.ch_rnw, e.rnw);
            if (!e.rnw) chk("req_din", bus.ch_din, e.din);
          end
          held  = req_t'{bus.ch_addr, bus.ch_rnw, bus.ch_din};
          outst = 1;
        end else if (outst) begin
          chk("hold_addr", bus.ch_addr, held.addr);
          chk("hold_rnw", bus.ch_rnw, held.rnw);
          chk("hold_din", bus.ch_din, held.din);
          if (bus.ch_ready) outst = 0;
        end
        if (outst || bus.mem_we) chk("busy_active", busy, 1);
        if (bus.mem_we) begin
          we_count++;
          if (exp_wr.size() == 0) begin
            fail_now("unexpected_mem_we");
          end else begin
            w = exp_wr.pop_front();
            chk("we_addr", bus.mem_addr, w.addr);
            chk("we_data", bus.mem_wdata, w.data);
          end
        end
        if (done) begin
          chk("done_error", error, exp_err);
          chk("done_busy", busy, 0);
          chk("left_reqs", exp_req.size(), 0);
          chk("left_writes", exp_wr.size(), 0);
        end
      end
    end
  end

  // Reference model: the full list of channel requests and RAM writes a command must produce.
  task automatic build(input logic d, input logic [26:0] base, input logic [AW:0] cnt, output logic inval);
    logic [26:0] b, a;
    logic [63:0] h;
    exp_req.delete(); exp_wr.delete();
    inval = 0; exp_err = 0;
    b = base & ~27'h3;
    if (d) begin
      if (cnt == 0 || cnt > DEPTH) begin
        exp_err = 1; inval = 1;
      end else begin
        exp_req.push_back(req_t'{b, 1'b0, {MAGIC, 21'd0, cnt}});
        for (int i = 0; i < int'(cnt); i++) begin
          a = b + 27'(4 * (i + 1));
          exp_req.push_back(req_t'{a, 1'b0, ram[i]});
        end
      end
    end else begin
      exp_req.push_back(req_t'{b, 1'b1, 64'h0});
      h = ddr_rd(b);
      if (h[63:32] != MAGIC || h[31:0] == 0 || h[31:0] > DEPTH) begin
        exp_err = 1;
      end else begin
        for (int i = 0; i < int'(h[31:0]); i++) begin
          a = b + 27'(4 * (i + 1));
          exp_req.push_back(req_t'{a, 1'b1, 64'h0});
          exp_wr.push_back(wr_t'{i[AW-1:0], ddr_rd(a)});
        end
      end
    end
  endtask

  task automatic run_cmd(input logic d, input logic [26:0] base, input logic [AW:0] cnt, input bit inject);
    logic inval;
    bit   got;
    build(d, base, cnt, inval);
    req_count = 0; we_count = 0;
    @(posedge DDRAM_CLK); #1;
    start = 1; dir = d; base_addr = base; word_cnt = cnt;
    @(posedge DDRAM_CLK); #1;
    start = 0; dir = 1'($urandom); base_addr = 27'($urandom); word_cnt = 11'($urandom);
    if (inval) begin
      chk("bad_done_next_cycle", done, 1);
      chk("bad_error", error, 1);
      chk("bad_busy", busy, 0);
    end else begin
      chk("accept_busy", busy, 1);
      chk("accept_clears_error", error, 0);
      chk("accept_done", done, 0);
    end
    got = 0;
    for (int n = 0; n < 20000; n++) begin
      if (done) begin got = 1; break; end
      start = inject && n == 3 && busy;
      if (start) begin dir = 1'($urandom); base_addr = 27'($urandom); word_cnt = 11'($urandom); end
      @(posedge DDRAM_CLK); #1;
    end
    start = 0;
    chk("done_seen", got, 1);
    @(posedge DDRAM_CLK); #1;
    chk("post_done_low", done, 0);
    chk("post_busy_low", busy, 0);
    chk("error_held", error, exp_err);
  endtask

  localparam logic [63:0] WA = 64'hAAAA_0000_1111_2222;
  localparam logic [63:0] WB = 64'hBBBB_3333_4444_5555;
  localparam logic [63:0] WC = 64'hCCCC_6666_7777_8888;
  localparam logic [63:0] WD = 64'hDDDD_9999_0000_1234;
  localparam logic [63:0] WE = 64'hEEEE_5678_9ABC_DEF0;

  initial begin
    logic [26:0] saved[$];
    logic [26:0] b;
    logic [AW:0] c;
    logic        inval;
    bit          got;
    int          rp0;

    reset_n = 1; start = 0; dir = 0; base_addr = '0; word_cnt = '0;
    for (int i = 0; i < DEPTH; i++) ram[i] = '0;
    #2 reset_n = 0;
    repeat (3) @(posedge DDRAM_CLK);
    #1;
    chk("reset_ch_addr", bus.ch_addr, 0);
    chk("reset_ch_din", bus.ch_din, 0);
    chk("reset_mem_addr", bus.mem_addr, 0);
    chk("reset_mem_wdata", bus.mem_wdata, 0);
    chk("reset_error", error, 0);
    chk("reset_ch_be", bus.ch_be, 8'hFF);
    reset_n = 1;

    lat_fix = 5;
    ram[0] = WA; ram[1] = WB; ram[2] = WC;
    run_cmd(1, 27'h100, 3, 0);
    chk("save3_reqs", req_count, 4);
    chk("save3_hdr", ddr_rd(27'h100), 64'h5353_0001_0000_0003);
    chk("save3_w0", ddr_rd(27'h104), WA);
    chk("save3_w1", ddr_rd(27'h108), WB);
    chk("save3_w2", ddr_rd(27'h10C), WC);
    chk("save3_error", error, 0);

    ram[0] = '0; ram[1] = '0; ram[2] = '0;
    run_cmd(0, 27'h100, 0, 0);
    chk("load3_r0", ram[0], WA);
    chk("load3_r1", ram[1], WB);
    chk("load3_r2", ram[2], WC);
    chk("load3_we_pulses", we_count, 3);
    chk("load3_error", error, 0);

    ddr[27'h200] = 64'hDEAD_BEEF_0000_0001;
    run_cmd(0, 27'h200, 0, 0);
    chk("badmagic_reqs", req_count, 1);
    chk("badmagic_we", we_count, 0);
    chk("badmagic_error", error, 1);

    run_cmd(1, 27'h300, 0, 0);
    chk("cnt0_reqs", req_count, 0);
    chk("cnt0_error", error, 1);
    run_cmd(1, 27'h300, 1, 0);
    chk("cnt1_error", error, 0);

    ram[0] = WD; ram[1] = WE;
    run_cmd(1, 27'h7FFFFFC, 2, 0);
    chk("wrap_hdr", ddr_rd(27'h7FFFFFC), 64'h5353_0001_0000_0002);
    chk("wrap_w0", ddr_rd(27'h0), WD);
    chk("wrap_w1", ddr_rd(27'h4), WE);

    lat_fix = 1;
    for (int i = 0; i < DEPTH; i++) ram[i] = {$urandom, $urandom};
    run_cmd(1, 27'h10000, 11'd1024, 0);
    for (int i = 0; i < DEPTH; i++) ram[i] = '0;
    run_cmd(0, 27'h10000, 0, 0);
    chk("full_we_pulses", we_count, 1024);
    run_cmd(1, 27'h20000, 11'd1025, 0);
    chk("cnt1025_reqs", req_count, 0);
    run_cmd(1, 27'h20000, 11'd2047, 0);
    ddr[27'h30000] = {MAGIC, 32'd1025};
    run_cmd(0, 27'h30000, 0, 0);
    chk("hdr1025_reqs", req_count, 1);
    ddr[27'h30000] = {MAGIC, 32'd0};
    run_cmd(0, 27'h30001, 0, 0);
    chk("hdr0_error", error, 1);

    lat_fix = 0; stray_en = 1;
    for (int k = 0; k < 40; k++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 5 || saved.size() == 0) begin
        c = ($urandom_range(0, 9) == 0) ? 11'd0 : 11'($urandom_range(1, 16));
        b = ($urandom_range(0, 3) == 0) ? 27'h7FFFFF0 + 27'($urandom_range(0, 15)) : 27'($urandom);
        for (int i = 0; i < int'(c); i++) ram[i] = {$urandom, $urandom};
        run_cmd(1, b, c, 1'($urandom));
        if (c != 0) saved.push_back(b & ~27'h3);
      end else if (sel < 8) begin
        b = saved[$urandom_range(0, saved.size() - 1)] | 27'($urandom_range(0, 3));
        run_cmd(0, b, 11'($urandom), 1'($urandom));
      end else begin
        b = 27'($urandom);
        case ($urandom_range(0, 3))
          0: ddr[b & ~27'h3] = {$urandom, 32'd2};
          1: ddr[b & ~27'h3] = {MAGIC, 32'd0};
          2: ddr[b & ~27'h3] = {MAGIC, 32'd1025};
          default: ddr[b & ~27'h3] = {MAGIC, 32'($urandom_range(1, 8))};
        endcase
        run_cmd(0, b, 11'($urandom), 1'($urandom));
      end
    end

    lat_fix = 8; stray_en = 0;
    for (int i = 0; i < 4; i++) ram[i] = {$urandom, $urandom};
    build(1, 27'h400, 4, inval);
    req_count = 0; we_count = 0;
    @(posedge DDRAM_CLK); #1;
    start = 1; dir = 1; base_addr = 27'h400; word_cnt = 4;
    @(posedge DDRAM_CLK); #1;
    start = 0;
    got = 0;
    for (int n = 0; n < 200; n++) begin
      if (req_count >= 2) begin got = 1; break; end
      @(posedge DDRAM_CLK); #1;
    end
    chk("rst_test_reached_dwait", got, 1);
    repeat (2) @(posedge DDRAM_CLK);
    #1;
    chk("rst_test_busy_before", busy, 1);
    rp0 = ready_pulses;
    #2 reset_n = 0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_req", bus.ch_req, 0);
    chk("async_rst_we", bus.mem_we, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_ch_addr", bus.ch_addr, 0);
    chk("async_rst_mem_addr", bus.mem_addr, 0);
    exp_req.delete(); exp_wr.delete();
    repeat (3) @(posedge DDRAM_CLK);
    #1 reset_n = 1;
    repeat (20) @(posedge DDRAM_CLK);
    #1;
    chk("late_ready_delivered", ready_pulses > rp0, 1);
    chk("rst_test_reqs", req_count, 2);
    chk("rst_test_we", we_count, 0);
    chk("rst_test_busy_after", busy, 0);
    chk("rst_test_done_after", done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
